// File: rtl/mux2.sv
// Two-input WIDTH-bit selector with zero-latency output, a registered copy
// and a saturating counter of registered-select toggles.
module mux2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_port,
  input  logic [WIDTH-1:0] port_in_0,
  input  logic [WIDTH-1:0] port_in_1,
  output logic [WIDTH-1:0] port_out,
  output logic [WIDTH-1:0] port_out_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] sel_toggle_cnt
);

  logic sel_next;
  logic cnt_sat;

  // Only a definite 1 selects input 1; 0, X and Z all fall through to input 0.
  always_comb begin
    sel_next = 1'b0;
    if (sel_port == 1'b1) sel_next = 1'b1;
  end

  always_comb begin
    port_out = port_in_0;
    if (sel_port == 1'b1) port_out = port_in_1;
  end

  assign cnt_sat = &sel_toggle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_out_q     <= '0;
      sel_q          <= 1'b0;
      sel_toggle_cnt <= '0;
    end else begin
      port_out_q <= port_out;
      sel_q      <= sel_next;
      if ((sel_next != sel_q) && !cnt_sat)
        sel_toggle_cnt <= sel_toggle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux2.sv
// Bench for mux2: combinational vector table, hand-written reset/toggle/saturation
// sequences and randomized traffic against a behavioural model.
module tb_mux2;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        sel_port = 1'b0;
  logic [31:0] port_in_0 = '0;
  logic [31:0] port_in_1 = '0;
  logic [31:0] port_out;
  logic [31:0] port_out_q;
  logic        sel_q;
  logic [15:0] sel_toggle_cnt;

  logic [7:0]  s_out;
  logic [7:0]  s_out_q;
  logic        s_sel_q;
  logic [1:0]  s_cnt;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset block: clock held static until the combinational checks are done
  always #5 if (clk_en) clk = ~clk;

  mux2 dut (
    .clk(clk), .rst(rst), .sel_port(sel_port),
    .port_in_0(port_in_0), .port_in_1(port_in_1),
    .port_out(port_out), .port_out_q(port_out_q),
    .sel_q(sel_q), .sel_toggle_cnt(sel_toggle_cnt)
  );

  mux2 #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .sel_port(sel_port),
    .port_in_0(port_in_0[7:0]), .port_in_1(port_in_1[7:0]),
    .port_out(s_out), .port_out_q(s_out_q),
    .sel_q(s_sel_q), .sel_toggle_cnt(s_cnt)
  );

  typedef struct {
    logic        sel;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  // behavioural model of the registered side
  logic [31:0] m_q;
  logic        m_sel;
  int          m_tog;

  function automatic logic [31:0] sat_of(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q   = '0;
    m_sel = 1'b0;
    m_tog = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, " port_out_q"}, port_out_q, m_q);
    check({tag, " sel_q"}, {31'b0, sel_q}, {31'b0, m_sel});
    check({tag, " cnt"}, {16'b0, sel_toggle_cnt}, sat_of(m_tog, 65535));
    check({tag, " sat_cnt"}, {30'b0, s_cnt}, sat_of(m_tog, 3));
    check({tag, " sat_q"}, {24'b0, s_out_q}, {24'b0, m_q[7:0]});
  endtask

  // driver: apply inputs on the falling edge, check after the next rising edge
  task automatic step(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    sel_port  = s;
    port_in_0 = a;
    port_in_1 = b;
    #1;
    check({tag, " port_out"}, port_out, s ? b : a);
    @(posedge clk);
    #1;
    m_q = s ? b : a;
    if (s != m_sel) m_tog++;
    m_sel = s;
    check_regs(tag);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_1111, 32'h1111_0000, 32'h1111_0000};
    vecs[1] = '{1'b0, 32'h0000_1111, 32'h1111_0000, 32'h0000_1111};
    vecs[2] = '{1'b0, 32'h0000_1001, 32'h1111_0000, 32'h0000_1001};
    vecs[3] = '{1'b0, 32'h0000_1001, 32'h2222_0000, 32'h0000_1001};
    vecs[4] = '{1'b0, 32'h0000_1001, 32'h1111_0000, 32'h0000_1001};
    vecs[5] = '{1'b1, 32'h0000_1001, 32'h1111_0000, 32'h1111_0000};
    vecs[6] = '{1'b1, 32'h1100_1111, 32'h1111_0000, 32'h1111_0000};
    vecs[7] = '{1'b1, 32'h1100_1111, 32'h1111_0011, 32'h1111_0011};
    vecs[8] = '{1'bx, 32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA};

    // combinational table, no clock, rst low
    for (int i = 0; i < 9; i++) begin
      sel_port  = vecs[i].sel;
      port_in_0 = vecs[i].in0;
      port_in_1 = vecs[i].in1;
      #10;
      check($sformatf("comb[%0d]", i), port_out, vecs[i].exp);
    end

    // asynchronous reset with the clock still stopped
    sel_port = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_regs("reset");
    check("reset port_out", port_out, port_in_0);

    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // toggle sequence 0,1,0,1 then 0,1,0 drives the 2-bit counter into saturation
    step("tog0", 1'b0, 32'h0000_0010, 32'h0000_0011);
    step("tog1", 1'b1, 32'h0000_0020, 32'h0000_0021);
    step("tog2", 1'b0, 32'h0000_0030, 32'h0000_0031);
    step("tog3", 1'b1, 32'h0000_0040, 32'h0000_0041);
    check("toggle count 3", {16'b0, sel_toggle_cnt}, 32'd3);
    step("tog4", 1'b0, 32'h0000_0050, 32'h0000_0051);
    step("tog5", 1'b1, 32'h0000_0060, 32'h0000_0061);
    step("tog6", 1'b0, 32'h0000_0070, 32'h0000_0071);
    check("sat stops at 3", {30'b0, s_cnt}, 32'd3);
    check("wide cnt 6", {16'b0, sel_toggle_cnt}, 32'd6);

    // mid-operation reset between edges
    @(negedge clk);
    port_in_0 = 32'hDEAD_BEEF;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_regs("midrst");
    check("midrst port_out", port_out, 32'hDEAD_BEEF);
    #1;
    rst = 1'b0;

    // first select value of 1 after reset counts as a toggle
    step("post1", 1'b1, 32'h0101_0101, 32'h0202_0202);
    check("post1 cnt 1", {16'b0, sel_toggle_cnt}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
